// File: rtl/dm_pkg.sv
// Shared encodings for dm_wait_mem: access sizes, controller states and wait counter width.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } dm_size_t;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACCESS,
    RESP
  } dm_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  // Alignment and size legality only; the range check needs DEPTH and lives in the top.
  function automatic logic dm_align_err(input logic [1:0] sz, input logic [1:0] a);
    logic e;
    case (sz)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = a[0];
      SZ_WORD: e = |a;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Lane steering for dm_wait_mem: load select/extend and store merge mask/data.
// DM_BIG_ENDIAN_EN selects big-endian lane numbering; undefined gives little-endian.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_wmask,
  output logic [31:0] o_wbits
);

  logic [1:0]  w_blane;
  logic        w_hlane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

`ifdef DM_BIG_ENDIAN_EN
  assign w_blane = i_addr_lo ^ 2'b11;
  assign w_hlane = ~i_addr_lo[1];
`else
  assign w_blane = i_addr_lo;
  assign w_hlane = i_addr_lo[1];
`endif

  assign w_byte = i_rdata[{w_blane, 3'b000} +: 8];
  assign w_half = i_rdata[{w_hlane, 4'b0000} +: 16];

  always_comb begin
    o_load  = '0;
    o_wmask = '0;
    o_wbits = '0;
    case (i_size)
      SZ_BYTE: begin
        o_load                           = {{24{i_sext & w_byte[7]}}, w_byte};
        o_wmask[{w_blane, 3'b000} +: 8]  = '1;
        o_wbits                          = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_load                           = {{16{i_sext & w_half[15]}}, w_half};
        o_wmask[{w_hlane, 4'b0000} +: 16] = '1;
        o_wbits                          = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_load  = i_rdata;
        o_wmask = '1;
        o_wbits = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_wait_mem.sv
// Word-array data memory with req/ready/rvalid handshake, wait states, error reporting and
// a post-reset clear engine. Endianness via DM_BIG_ENDIAN_EN (handled in dm_lane_unit).
module dm_wait_mem
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned TEST_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [1:0]             size,
  input  logic                   sext,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [31:0]            din,
  output logic                   ready,
  output logic                   rvalid,
  output logic [31:0]            dout,
  output logic                   err,
  input  logic [TEST_ADDR_W-1:0] test_addr,
  output logic [31:0]            test_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  logic [31:0]           r_mem [DEPTH];
  dm_state_t             r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sext;
  logic [31:0]           r_din;
  logic                  r_ready;
  logic                  r_rvalid;
  logic                  r_err;
  logic [31:0]           r_dout;

  logic                  w_in_range;
  logic                  w_req_err;
  logic                  w_accept;
  logic                  w_do_op;
  logic                  w_st_we;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_tidx;
  logic [31:0]           w_rword;
  logic [31:0]           w_load;
  logic [31:0]           w_wmask;
  logic [31:0]           w_wbits;
  logic [31:0]           w_merged;

  assign w_in_range = 32'(addr[ADDR_W-1:2]) < 32'(DEPTH);
  assign w_req_err  = dm_align_err(size, addr[1:0]) | ~w_in_range;
  assign w_accept   = req & r_ready;

  assign w_idx    = PTR_W'(r_addr[ADDR_W-1:2]);
  assign w_rword  = r_mem[w_idx];
  assign w_do_op  = (r_state == ACCESS) && (r_cnt == '0);
  assign w_st_we  = w_do_op & r_we;
  assign w_merged = (w_rword & ~w_wmask) | (w_wbits & w_wmask);

  dm_lane_unit u_lane (
    .i_size    (r_size),
    .i_sext    (r_sext),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (w_rword),
    .i_wdata   (r_din),
    .o_load    (w_load),
    .o_wmask   (w_wmask),
    .o_wbits   (w_wbits)
  );

  // Storage carries no reset; the clear engine zeroes it word by word instead.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_st_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign w_tidx    = PTR_W'(test_addr);
  assign test_data = (32'(test_addr) < 32'(DEPTH)) ? r_mem[w_tidx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= CLEAR;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_sext   <= 1'b0;
      r_din    <= '0;
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == PTR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (w_accept) begin
            r_addr  <= addr;
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sext;
            r_din   <= din;
            r_ready <= 1'b0;
            r_dout  <= '0;
            if (w_req_err) begin
              r_state  <= RESP;
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
            end else begin
              r_state <= ACCESS;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
            if (!r_we) begin
              r_dout <= w_load;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign ready  = r_ready;
  assign rvalid = r_rvalid;
  assign dout   = r_dout;
  assign err    = r_err;

endmodule

// File: tb/tb_dm_wait_mem.sv
// Scoreboard bench for dm_wait_mem: byte-addressed reference memory, queued expectations,
// independent monitor on rvalid. Endianness of the model follows DM_BIG_ENDIAN_EN.
module tb_dm_wait_mem;

  localparam int unsigned AW  = 13;
  localparam int unsigned DEP = 1024;
  localparam int unsigned WC  = 1;
  localparam int unsigned TW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sext = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   din = '0;
  logic          ready;
  logic          rvalid;
  logic [31:0]   dout;
  logic          err;
  logic [TW-1:0] test_addr = '0;
  logic [31:0]   test_data;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  dm_wait_mem #(
    .ADDR_W      (AW),
    .DEPTH       (DEP),
    .WAIT_CYCLES (WC),
    .TEST_ADDR_W (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sext      (sext),
    .addr      (addr),
    .din       (din),
    .ready     (ready),
    .rvalid    (rvalid),
    .dout      (dout),
    .err       (err),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  typedef struct {
    logic        e_err;
    logic [31:0] e_dout;
    int unsigned t0;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mbytes [DEP*4];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=0x%08h want=0x%08h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic void model_clear();
    for (int unsigned i = 0; i < DEP*4; i++) mbytes[i] = 8'h00;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned w);
`ifdef DM_BIG_ENDIAN_EN
    return {mbytes[4*w], mbytes[4*w+1], mbytes[4*w+2], mbytes[4*w+3]};
`else
    return {mbytes[4*w+3], mbytes[4*w+2], mbytes[4*w+1], mbytes[4*w]};
`endif
  endfunction

  function automatic logic [31:0] model_load(input int unsigned a, input int unsigned n,
                                             input logic sx);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) begin
`ifdef DM_BIG_ENDIAN_EN
      v = (v << 8) | 32'(mbytes[a+i]);
`else
      v = v | (32'(mbytes[a+i]) << (8*i));
`endif
    end
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic void model_store(input int unsigned a, input int unsigned n,
                                      input logic [31:0] d);
    for (int unsigned i = 0; i < n; i++) begin
`ifdef DM_BIG_ENDIAN_EN
      mbytes[a+i] = d[8*(n-1-i) +: 8];
`else
      mbytes[a+i] = d[8*i +: 8];
`endif
    end
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input int unsigned a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= DEP) return 1'b1;
    return 1'b0;
  endfunction

  // Hold req until ready is seen, then predict the response and queue it.
  task automatic access(input logic iwe, input logic [1:0] isz, input logic isx,
                        input int unsigned ia, input logic [31:0] id);
    exp_t        e;
    int unsigned n;
    int unsigned nb;
    @(negedge clk);
    req  = 1'b1;
    we   = iwe;
    size = isz;
    sext = isx;
    addr = AW'(ia);
    din  = id;
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
    if (!ready) begin
      req = 1'b0;
      return;
    end
    nb       = (isz == 2'b00) ? 1 : (isz == 2'b01) ? 2 : 4;
    e.e_err  = model_err(isz, ia);
    e.e_dout = '0;
    e.t0     = cyc;
    if (!e.e_err) begin
      if (iwe) model_store(ia, nb, id);
      else     e.e_dout = model_load(ia, nb, isx);
    end
    q.push_back(e);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic check_test_port(input string nm, input int unsigned w);
    @(negedge clk);
    test_addr = TW'(w);
    #1;
    chk(nm, test_data, model_word(w));
  endtask

  task automatic release_and_time();
    int unsigned n;
    n = 0;
    @(negedge clk);
    rst = 1'b1;
    while (!ready && n < DEP + 50) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles", n, DEP);
  endtask

  // Monitor: every rvalid pulse is matched against the oldest queued expectation.
  initial begin
    exp_t        e;
    int unsigned lat;
    forever begin
      @(negedge clk);
      if (rst && rvalid) begin
        if (q.size() == 0) begin
          chk("spurious_rvalid", 32'(rvalid), 32'd0);
        end else begin
          e   = q.pop_front();
          lat = cyc - e.t0;
          chk("rsp_err", 32'(err), 32'(e.e_err));
          chk("rsp_dout", dout, e.e_dout);
          chk("rsp_latency", lat, e.e_err ? 32'd1 : WC + 2);
          @(negedge clk);
          chk("rvalid_pulse", {30'd0, rvalid, err}, 32'd0);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rst       = 1'b0;
    test_addr = TW'(3);
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    release_and_time();
    check_test_port("clear_test_data", 3);

    // Directed sequence
    access(1'b1, 2'b10, 1'b0, 'h010, 32'h1122_3344);
    access(1'b0, 2'b00, 1'b1, 'h010, 32'h0);
    access(1'b0, 2'b00, 1'b1, 'h013, 32'h0);
    access(1'b1, 2'b00, 1'b0, 'h011, 32'h0000_0080);
    wait_done();
    check_test_port("byte_store_test_data", 4);
    access(1'b0, 2'b00, 1'b1, 'h011, 32'h0);
    access(1'b0, 2'b00, 1'b0, 'h011, 32'h0);
    access(1'b0, 2'b01, 1'b1, 'h012, 32'h0);
    access(1'b0, 2'b01, 1'b1, 'h013, 32'h0);
    access(1'b1, 2'b10, 1'b0, 'h012, 32'hCAFE_F00D);
    access(1'b1, 2'b10, 1'b0, 'h1000, 32'hCAFE_F00D);
    access(1'b1, 2'b11, 1'b0, 'h014, 32'hCAFE_F00D);
    access(1'b0, 2'b10, 1'b0, 'h010, 32'h0);
    wait_done();
    check_test_port("err_no_write_w4", 4);
    check_test_port("err_no_write_w5", 5);

    // Randomized traffic, back-to-back so req is also held through busy cycles
    for (int k = 0; k < 160; k++) begin
      int unsigned a;
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << AW) - 1)
                                      : $urandom_range(0, 127);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
      if (k % 16 == 15) begin
        wait_done();
        check_test_port("rand_test_data", $urandom_range(0, 31));
      end
    end
    wait_done();

    // Reset in the middle of a store's ACCESS phase
    access(1'b1, 2'b10, 1'b0, 'h020, 32'hDEAD_BEEF);
    rst = 1'b0;
    q.delete();
    model_clear();
    repeat (4) @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    release_and_time();
    access(1'b0, 2'b10, 1'b0, 'h020, 32'h0);
    wait_done();
    check_test_port("midrst_test_data", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_wait_mem.md
Name: dm_wait_mem

Overview:
- Parametrised successor to the 4K data memory.
- Word array of configurable depth with byte, halfword and word load/store, and sign or zero extension on loads.
- Replaces the combinational read and clocked write with a req/ready/rvalid handshake, programmable wait states, misalignment/range error reporting and a sequential post-reset clear engine.
- Sits between the CPU load/store stage and storage; keeps the test read port for on-board display.

Parameters:
- ADDR_W, 12, byte-address width.
- DEPTH, 1024, number of 32-bit words; must be ≤ 2**(ADDR_W-2).
- WAIT_CYCLES, 0, extra access cycles inserted before the memory operation (0..15).
- TEST_ADDR_W, 5, width of the test word index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- din  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  block can accept req this cycle.
- rvalid  out  1  one-cycle completion pulse, loads and stores.
- dout  out  32  load result, extended; 0 for stores and errors.
- err  out  1  qualified by rvalid; misaligned, illegal size or out of range.
- test_addr  in  TEST_ADDR_W  debug word index.
- test_data  out  32  combinational word at test_addr; 0 if index ≥ DEPTH.

Behaviour:
- Reset (rst low, asynchronous):
  - state = CLEAR, clear pointer = 0.
  - ready = 0, rvalid = 0, dout = 0, err = 0.
  - Any in-flight access is aborted and a pending store is lost.
- CLEAR:
  - Each clk writes 0 to word[ptr], then ptr++.
  - After word DEPTH-1 is written, go to IDLE.
  - ready is first high exactly DEPTH cycles after rst deasserts.
- IDLE:
  - ready = 1.
  - Accept on the edge where req && ready: latch addr, we, size, sext, din.
  - Error if any of: size = 11; half with addr[0] = 1; word with addr[1:0] ≠ 00; addr[ADDR_W-1:2] ≥ DEPTH.
  - On error go to RESP with err = 1; memory is untouched.
  - Otherwise go to ACCESS with cnt = WAIT_CYCLES.
- ACCESS:
  - ready = 0.
  - If cnt ≠ 0, decrement cnt.
  - If cnt = 0, perform the operation on this edge and go to RESP.
  - Store: read-modify-write with only the selected lanes replaced.
  - Load: select lane(s), extend per sext, register into dout.
- RESP:
  - rvalid = 1 for exactly one cycle; err and dout valid in that cycle; ready = 0.
  - Next state IDLE. dout holds until the next acceptance; err clears with rvalid.
- Latency: acceptance edge to rvalid high = WAIT_CYCLES + 2 edges; error path = 1 edge. Max throughput is one access per WAIT_CYCLES + 3 cycles.
- req while ready = 0 is ignored, not queued; the master must hold req until it sees ready.
- test_data reflects writes from the following cycle; no read-during-write bypass is required on the test port.
- A load of the word just stored by the previous access returns the new data.

Optional Feature:
- Macro: DM_BIG_ENDIAN_EN.
- Defined: byte lane = addr[1:0] ^ 2'b11; half lane = addr[1] ^ 1 (address 0 maps to bits [31:24]).
- Undefined: little-endian; byte lane = addr[1:0], half lane = addr[1].
- Handshake, error rules and word access are identical in both builds.

Decomposition:
- Package dm_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encoding CLEAR, IDLE, ACCESS, RESP.
  - WAIT_CYCLES counter width constant.
- Sub-module dm_lane_unit (combinational): lane select plus extend for loads; store merge mask and data for stores. Endianness is handled only here.

Test Plan (DM_BIG_ENDIAN_EN defined, WAIT_CYCLES = 1):
- Release rst, drive test_addr = 3 -> ready low 1024 cycles then high; test_data = 0x00000000.
- Store word 0x11223344 at 0x010, then load byte at 0x010 with sext = 1 -> dout 0x00000011; load byte at 0x013 -> 0x00000044; rvalid occurs 3 edges after each acceptance.
- Store byte 0x80 at 0x011 -> test_data[4] = 0x11803344; load byte at 0x011 with sext = 1 -> 0xFFFFFF80; with sext = 0 -> 0x00000080.
- Load half at 0x012 with sext = 1 -> 0x00003344; load half at 0x013 -> rvalid with err = 1, dout = 0.
- Store word at 0x012 or address 0x1000-equivalent beyond DEPTH -> err = 1 one edge after acceptance; target words unchanged.
- Assert rst low during ACCESS of a store 0xDEADBEEF -> rvalid never pulses; ready returns after 1024 cycles; the word reads 0.
